// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - IF/MEM arbiter for the single external memory bus
//
// Purpose: shares one external memory bus between instruction fetch (IF)
// and data access (MEM). One transaction is in flight at a time, and MEM
// has priority. Flushed fetches are still completed on the bus, but their
// data is discarded. All bus-side and requester-side response outputs are
// registered. The stall outputs are combinational.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   if_req_i/addr_i   fetch request (held until if_ack_o) and address
//   if_ack_o/rdata_o  one-cycle fetch completion pulse and instruction word
//   mem_req_i/we_i/sel_i/addr_i/wdata_i  data request and its fields
//   mem_ack_o/rdata_o one-cycle data completion pulse and load data
//   flush_i           pipeline flush; cancels the pending or in-flight fetch
//   bus_stb_o/we_o/sel_o/addr_o/wdata_o  bus master outputs
//   bus_rdata_i/ack_i bus slave response
//   stall_if_o        fetch waiting
//   stall_mem_o       data access waiting
//   timeout_err_o     sticky bus-timeout flag
//
// Build option: define ARB_TIMEOUT_EN to abort transactions whose strobe
// waits TIMEOUT_CYCLES cycles without an ack.

`timescale 1ns/1ps

module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  input  logic        flush_i,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        timeout_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF_BUS,
    S_MEM_BUS,
    S_IF_DROP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic        w_mem_pend;
  logic        w_if_pend;
  logic        w_grant_mem;
  logic        w_grant_if;
  logic        w_cap_mem;
  logic        w_cap_if;
  logic        w_release;
  logic        w_zero_data;
  logic        w_timeout;
  logic [31:0] w_cap_data;

  // Requesters keep their request high through the ack-pulse cycle. Masking
  // with the registered ack prevents a finished transaction from being
  // granted again in that same cycle.
  assign w_mem_pend  = mem_req_i & ~mem_ack_o;
  assign w_if_pend   = if_req_i & ~if_ack_o;
  assign stall_mem_o = w_mem_pend;
  assign stall_if_o  = w_if_pend;

  // An aborted transaction returns zero data instead of the idle bus value.
  assign w_cap_data = w_zero_data ? 32'h0 : bus_rdata_i;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout_err;

  // Fires in the TIMEOUT_CYCLES-th consecutive cycle the strobe waits, so
  // the strobe is low on the following cycle.
  assign w_timeout = bus_stb_o & ~bus_ack_i &
                     (({1'b0, r_wait_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_grant_mem | w_grant_if) begin
        r_wait_cnt <= 8'd0;
      end else if (bus_stb_o & ~bus_ack_i) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err_o = r_timeout_err;
`else
  // The timeout length has no effect when the abort logic is compiled out.
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

  assign w_timeout     = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_grant_mem  = 1'b0;
    w_grant_if   = 1'b0;
    w_cap_mem    = 1'b0;
    w_cap_if     = 1'b0;
    w_release    = 1'b0;
    w_zero_data  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_pend) begin
          w_grant_mem  = 1'b1;
          w_state_next = S_MEM_BUS;
        end else if (w_if_pend && !flush_i) begin
          w_grant_if   = 1'b1;
          w_state_next = S_IF_BUS;
        end
      end
      S_MEM_BUS: begin
        // Stores and loads always complete; flush is not looked at here.
        if (bus_ack_i) begin
          w_cap_mem    = 1'b1;
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_cap_mem    = 1'b1;
          w_zero_data  = 1'b1;
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_IF_BUS: begin
        if (bus_ack_i) begin
          // A flush in the ack cycle discards the word silently.
          w_cap_if     = ~flush_i;
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_cap_if     = ~flush_i;
          w_zero_data  = 1'b1;
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end else if (flush_i) begin
          w_state_next = S_IF_DROP;
        end
      end
      S_IF_DROP: begin
        // The slave still owes an ack, so the strobe stays high until it
        // arrives. The fetched word is discarded.
        if (bus_ack_i || w_timeout) begin
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      bus_stb_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'h0;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      if_ack_o    <= 1'b0;
      if_rdata_o  <= 32'h0;
      mem_ack_o   <= 1'b0;
      mem_rdata_o <= 32'h0;
    end else begin
      r_state   <= w_state_next;
      if_ack_o  <= w_cap_if;
      mem_ack_o <= w_cap_mem;
      if (w_cap_if) begin
        if_rdata_o <= w_cap_data;
      end
      if (w_cap_mem) begin
        mem_rdata_o <= w_cap_data;
      end
      // Bus fields are loaded only on the grant edge. Changes made by a
      // requester mid-transaction never reach the bus.
      if (w_grant_mem) begin
        bus_stb_o   <= 1'b1;
        bus_we_o    <= mem_we_i;
        bus_sel_o   <= mem_sel_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
      end else if (w_grant_if) begin
        bus_stb_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_sel_o   <= 4'hF;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= 32'h0;
      end else if (w_release) begin
        bus_stb_o   <= 1'b0;
      end
    end
  end

endmodule
